// File: rtl/timer_regfile_mc.sv
// timer_regfile_mc: APB register file and counter core for the multi-channel timer.
// It holds the control and compare registers and runs the prescaler and the up-counter.
// It also raises a per-channel match status and drives the registered interrupt outputs.
module timer_regfile_mc #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [11:0]       paddr,
   input  logic [31:0]       pwdata,
   input  logic [3:0]        pstrb,
   output logic [31:0]       prdata,
   output logic              pready,
   output logic              pslverr,
   input  logic              dbg_mode,
   output logic [63:0]       cnt_value,
   output logic              tim_int,
   output logic [NUM_CH-1:0] tim_int_ch
);

   localparam logic [11:0] ADDR_TCR   = 12'h000;
   localparam logic [11:0] ADDR_TDR0  = 12'h004;
   localparam logic [11:0] ADDR_TDR1  = 12'h008;
   localparam logic [11:0] ADDR_TIER  = 12'h00C;
   localparam logic [11:0] ADDR_TISR  = 12'h010;
   localparam logic [11:0] ADDR_THCSR = 12'h014;

   logic              timer_en;
   logic              div_en;
   logic [3:0]        div_val;
   logic              auto_clr;
   logic              halt_req;
   logic              halted;
   logic [CNT_W-1:0]  cnt;
   logic [7:0]        presc;
   logic [NUM_CH-1:0] int_en;
   logic [NUM_CH-1:0] status;
   logic [NUM_CH-1:0] match;
   logic [NUM_CH-1:0] clr_mask;
   logic [31:0]       tcmp_lo [NUM_CH];
   logic [31:0]       tcmp_hi [NUM_CH];
   logic [63:0]       cmp_full;

   logic              wr_acc;
   logic              rd_acc;
   logic [31:0]       tcr_word;
   logic              new_timer_en;
   logic              new_div_en;
   logic [3:0]        new_div_val;
   logic              new_auto_clr;
   logic              tcr_err;
   logic              tcr_we;
   logic [63:0]       cnt_ext;
   logic [63:0]       cnt_load;
   logic              cnt_we;
   logic [8:0]        presc_span;
   logic              presc_last;
   logic              tick;

   // Byte-lane merge: strobed lanes take the new data, the rest keep the old word.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
      end
      return res;
   endfunction

   assign wr_acc    = psel && penable && pwrite;
   assign rd_acc    = psel && penable && !pwrite;
   assign pready    = 1'b1;
   assign halted    = halt_req && dbg_mode;
   assign cnt_ext   = 64'(cnt);
   assign cnt_value = cnt_ext;
   assign tcr_word  = {15'd0, auto_clr, 4'd0, div_val, 6'd0, div_en, timer_en};

   // TCR write decode: the would-be field values and the reasons to reject the whole write.
   always_comb begin
      new_timer_en = pstrb[0] ? pwdata[0]    : timer_en;
      new_div_en   = pstrb[0] ? pwdata[1]    : div_en;
      new_div_val  = pstrb[1] ? pwdata[11:8] : div_val;
      new_auto_clr = pstrb[2] ? pwdata[16]   : auto_clr;
      tcr_err      = (pstrb[1] && (pwdata[11:8] > 4'd8)) ||
                     (timer_en && ((new_div_en != div_en) || (new_div_val != div_val)));
      tcr_we       = wr_acc && (paddr == ADDR_TCR) && !tcr_err;
      pslverr      = wr_acc && (paddr == ADDR_TCR) && tcr_err;
   end

   // Software load of the counter through TDR0/TDR1, byte by byte.
   always_comb begin
      cnt_load = cnt_ext;
      cnt_we   = 1'b0;
      if (wr_acc && (paddr == ADDR_TDR0)) begin
         cnt_load[31:0] = merge_bytes(cnt_ext[31:0], pwdata, pstrb);
         cnt_we         = 1'b1;
      end else if (wr_acc && (paddr == ADDR_TDR1)) begin
         cnt_load[63:32] = merge_bytes(cnt_ext[63:32], pwdata, pstrb);
         cnt_we          = 1'b1;
      end
   end

   // Tick when the timer runs unhalted, either every cycle or at the end of a prescaler period.
   always_comb begin
      presc_span = 9'd1 << div_val;
      presc_last = ({1'b0, presc} == (presc_span - 9'd1));
      tick       = timer_en && !halted && (!div_en || presc_last);
   end

   // Compare every channel against the counter, truncated to the implemented width.
   always_comb begin
      cmp_full = '0;
      match    = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         cmp_full = {tcmp_hi[k], tcmp_lo[k]};
         match[k] = (cnt == cmp_full[CNT_W-1:0]);
      end
   end

   assign clr_mask = (wr_acc && (paddr == ADDR_TISR) && pstrb[0]) ? pwdata[NUM_CH-1:0] : '0;

   // Read mux: only drives data during a read access phase, unmapped addresses read 0.
   always_comb begin
      prdata = '0;
      if (rd_acc) begin
         case (paddr)
            ADDR_TCR:   prdata = tcr_word;
            ADDR_TDR0:  prdata = cnt_ext[31:0];
            ADDR_TDR1:  prdata = cnt_ext[63:32];
            ADDR_TIER:  prdata = 32'(int_en);
            ADDR_TISR:  prdata = 32'(status);
            ADDR_THCSR: prdata = {30'd0, halted, halt_req};
            default: begin
               for (int k = 0; k < NUM_CH; k++) begin
                  if (paddr == 12'(32 + 8*k)) prdata = tcmp_lo[k];
                  if (paddr == 12'(36 + 8*k)) prdata = tcmp_hi[k];
               end
            end
         endcase
      end
   end

   // Software-visible configuration registers: TCR, TIER, THCSR and the compare values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_en <= 1'b0;
         div_en   <= 1'b0;
         div_val  <= 4'd1;
         auto_clr <= 1'b0;
         int_en   <= '0;
         halt_req <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            tcmp_lo[k] <= '1;
            tcmp_hi[k] <= '1;
         end
      end else begin
         if (tcr_we) begin
            timer_en <= new_timer_en;
            div_en   <= new_div_en;
            div_val  <= new_div_val;
            auto_clr <= new_auto_clr;
         end
         if (wr_acc && (paddr == ADDR_TIER) && pstrb[0]) begin
            int_en <= pwdata[NUM_CH-1:0];
         end
         if (wr_acc && (paddr == ADDR_THCSR) && pstrb[0]) begin
            halt_req <= pwdata[0];
         end
         for (int k = 0; k < NUM_CH; k++) begin
            if (wr_acc && (paddr == 12'(32 + 8*k))) begin
               tcmp_lo[k] <= merge_bytes(tcmp_lo[k], pwdata, pstrb);
            end
            if (wr_acc && (paddr == 12'(36 + 8*k))) begin
               tcmp_hi[k] <= merge_bytes(tcmp_hi[k], pwdata, pstrb);
            end
         end
      end
   end

   // Prescaler restarts whenever division is not in effect and wraps at the end of each period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
      end else if (!timer_en || !div_en || halted || presc_last) begin
         presc <= '0;
      end else begin
         presc <= presc + 8'd1;
      end
   end

   // Counter: stopping the timer clears it, a software load beats a tick, auto-clear folds at TCMP0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (tcr_we && timer_en && !new_timer_en) begin
         cnt <= '0;
      end else if (cnt_we) begin
         cnt <= cnt_load[CNT_W-1:0];
      end else if (tick) begin
         cnt <= (auto_clr && match[0]) ? '0 : cnt + CNT_W'(1);
      end
   end

   // Sticky match status; a set in the same cycle as a write-1-to-clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status <= '0;
      end else begin
         status <= (status & ~clr_mask) | match;
      end
   end

   // Registered interrupt outputs from the enabled status bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tim_int    <= 1'b0;
         tim_int_ch <= '0;
      end else begin
         tim_int    <= |(status & int_en);
         tim_int_ch <= status & int_en;
      end
   end

endmodule

// File: tb/tb_timer_regfile_mc.sv
// tb_timer_regfile_mc: directed and randomized APB traffic against a behavioural timer model.
module tb_timer_regfile_mc;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 64;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              psel = 1'b0;
   logic              penable = 1'b0;
   logic              pwrite = 1'b0;
   logic [11:0]       paddr = '0;
   logic [31:0]       pwdata = '0;
   logic [3:0]        pstrb = '0;
   logic [31:0]       prdata;
   logic              pready;
   logic              pslverr;
   logic              dbg_mode = 1'b0;
   logic [63:0]       cnt_value;
   logic              tim_int;
   logic [NUM_CH-1:0] tim_int_ch;

   int   checks = 0;
   int   errors = 0;
   logic chkEn = 1'b0;

   // Reference model state
   logic [63:0] m_cnt;
   logic        m_en, m_div, m_auto, m_halt;
   logic [3:0]  m_dv;
   logic [3:0]  m_ien, m_st, m_ich;
   logic        m_int;
   logic [63:0] m_cmp [NUM_CH];
   int          m_presc;

   timer_regfile_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
      .pslverr(pslverr), .dbg_mode(dbg_mode), .cnt_value(cnt_value), .tim_int(tim_int),
      .tim_int_ch(tim_int_ch)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] mergeBytes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] tcrWord();
      return {15'd0, m_auto, 4'd0, m_dv, 6'd0, m_div, m_en};
   endfunction

   function automatic logic expErr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] nw;
      if (a != 12'h000) return 1'b0;
      nw = mergeBytes(tcrWord(), d, s);
      if (s[1] && d[11:8] > 4'd8) return 1'b1;
      if (m_en && (nw[1] != m_div || nw[11:8] != m_dv)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] expRead(input logic [11:0] a);
      logic [31:0] r;
      r = '0;
      case (a)
         12'h000: r = tcrWord();
         12'h004: r = m_cnt[31:0];
         12'h008: r = m_cnt[63:32];
         12'h00C: r = {28'd0, m_ien};
         12'h010: r = {28'd0, m_st};
         12'h014: r = {30'd0, m_halt && dbg_mode, m_halt};
         default: begin
            for (int k = 0; k < NUM_CH; k++) begin
               if (a == 12'(32 + 8*k)) r = m_cmp[k][31:0];
               if (a == 12'(36 + 8*k)) r = m_cmp[k][63:32];
            end
         end
      endcase
      return r;
   endfunction

   function automatic void modelReset();
      m_cnt = '0; m_en = 1'b0; m_div = 1'b0; m_dv = 4'd1; m_auto = 1'b0; m_halt = 1'b0;
      m_ien = '0; m_st = '0; m_ich = '0; m_int = 1'b0; m_presc = 0;
      for (int k = 0; k < NUM_CH; k++) m_cmp[k] = '1;
   endfunction

   function automatic void modelStep();
      logic        wr, halted, tick, err;
      logic [3:0]  hit, clr;
      logic [31:0] nw;
      logic [63:0] nextCnt;
      wr = psel && penable && pwrite;
      halted = m_halt && dbg_mode;
      tick = 1'b0;
      if (m_en && !halted) begin
         if (!m_div) begin
            tick = 1'b1;
            m_presc = 0;
         end else begin
            m_presc++;
            if (m_presc >= (1 << m_dv)) begin
               tick = 1'b1;
               m_presc = 0;
            end
         end
      end else begin
         m_presc = 0;
      end
      for (int k = 0; k < NUM_CH; k++) hit[k] = (m_cnt == m_cmp[k]);
      clr = (wr && paddr == 12'h010 && pstrb[0]) ? pwdata[3:0] : 4'd0;
      err = wr && expErr(paddr, pwdata, pstrb);
      nw = mergeBytes(tcrWord(), pwdata, pstrb);
      nextCnt = m_cnt;
      if (wr && paddr == 12'h000 && !err && m_en && !nw[0]) nextCnt = '0;
      else if (wr && paddr == 12'h004) nextCnt[31:0] = mergeBytes(m_cnt[31:0], pwdata, pstrb);
      else if (wr && paddr == 12'h008) nextCnt[63:32] = mergeBytes(m_cnt[63:32], pwdata, pstrb);
      else if (tick) nextCnt = (m_auto && m_cnt == m_cmp[0]) ? 64'd0 : m_cnt + 64'd1;
      m_ich = m_st & m_ien;
      m_int = |(m_st & m_ien);
      m_st = (m_st & ~clr) | hit;
      m_cnt = nextCnt;
      if (wr) begin
         case (paddr)
            12'h000: if (!err) begin
               m_en = nw[0]; m_div = nw[1]; m_dv = nw[11:8]; m_auto = nw[16];
            end
            12'h00C: if (pstrb[0]) m_ien = pwdata[3:0];
            12'h014: if (pstrb[0]) m_halt = pwdata[0];
            default: begin
               for (int k = 0; k < NUM_CH; k++) begin
                  if (paddr == 12'(32 + 8*k)) m_cmp[k][31:0] = mergeBytes(m_cmp[k][31:0], pwdata, pstrb);
                  if (paddr == 12'(36 + 8*k)) m_cmp[k][63:32] = mergeBytes(m_cmp[k][63:32], pwdata, pstrb);
               end
            end
         endcase
      end
   endfunction

   // Advance the reference model on every clock edge, or reset it with the DUT.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) modelReset();
      else modelStep();
   end

   // Continuously compare the free-running outputs with the model away from the clock edge.
   always @(negedge clk) begin
      if (chkEn && rst_n) begin
         checkOutput("cnt_value", cnt_value, m_cnt);
         checkOutput("tim_int", 64'(tim_int), 64'(m_int));
         checkOutput("tim_int_ch", 64'(tim_int_ch), 64'(m_ich));
         checkOutput("pready", 64'(pready), 64'd1);
         if (!(psel && penable)) checkOutput("prdata_idle", 64'(prdata), 64'd0);
      end
   end

   task automatic apbWrite(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s, output logic err);
      logic e;
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d; pstrb = s;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      e = expErr(a, d, s);
      err = pslverr;
      checkOutput($sformatf("pslverr_wr_%0h", a), 64'(pslverr), 64'(e));
      checkOutput("prdata_on_write", 64'(prdata), 64'd0);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apbRead(input logic [11:0] a, output logic [31:0] d);
      logic [31:0] e;
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      e = expRead(a);
      d = prdata;
      checkOutput($sformatf("prdata_rd_%0h", a), 64'(prdata), 64'(e));
      checkOutput("pslverr_rd", 64'(pslverr), 64'd0);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic waitCnt(input logic [63:0] target, input int budget, input string tag);
      logic found;
      found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if (cnt_value == target) found = 1'b1;
      end
      checkOutput(tag, 64'(found), 64'd1);
   endtask

   // Random mix of register writes, reads, debug toggles and idle gaps.
   task automatic applyStimulus(input int n);
      logic [31:0] d;
      logic [11:0] a;
      logic        e;
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 9))
            0: begin
               d = '0;
               d[0] = 1'($urandom_range(0, 1));
               d[1] = 1'($urandom_range(0, 1));
               d[11:8] = 4'($urandom_range(0, 9));
               d[16] = 1'($urandom_range(0, 1));
               apbWrite(12'h000, d, 4'($urandom), e);
            end
            1: apbWrite(12'h004, 32'($urandom_range(0, 20)), 4'($urandom), e);
            2: apbWrite(12'h008, 32'($urandom_range(0, 3) == 0), 4'($urandom), e);
            3: apbWrite(12'h00C, $urandom, 4'($urandom), e);
            4: apbWrite(12'h010, $urandom, 4'($urandom), e);
            5: apbWrite(12'h014, $urandom, 4'($urandom), e);
            6: begin
               a = 12'(32 + 4 * $urandom_range(0, 7));
               d = a[2] ? 32'd0 : 32'($urandom_range(0, 30));
               apbWrite(a, d, 4'hF, e);
            end
            7: apbRead(12'(4 * $urandom_range(0, 24)), d);
            8: begin
               @(posedge clk); #1;
               dbg_mode = 1'($urandom_range(0, 1));
            end
            default: repeat ($urandom_range(1, 4)) @(posedge clk);
         endcase
      end
   endtask

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] d;
      logic        e;
      logic [31:0] exp32;
      logic [63:0] frozen;
      int          n;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_cnt", cnt_value, 64'd0);
      checkOutput("rst_int", 64'(tim_int), 64'd0);
      checkOutput("rst_int_ch", 64'(tim_int_ch), 64'd0);
      checkOutput("rst_prdata", 64'(prdata), 64'd0);
      checkOutput("rst_pslverr", 64'(pslverr), 64'd0);
      rst_n = 1'b1;
      chkEn = 1'b1;

      // Reset register map
      for (int i = 0; i < 20; i++) begin
         apbRead(12'(4 * i), d);
         exp32 = (i == 0) ? 32'h100 : ((i >= 8 && i < 16) ? 32'hFFFF_FFFF : 32'h0);
         checkOutput($sformatf("rst_map_%0h", 4 * i), 64'(d), 64'(exp32));
      end
      apbRead(12'hFFC, d);
      checkOutput("rst_map_ffc", 64'(d), 64'd0);

      // Compare channel 1 match and interrupt latency
      apbWrite(12'h028, 32'd5, 4'hF, e);
      apbWrite(12'h02C, 32'd0, 4'hF, e);
      apbWrite(12'h00C, 32'h2, 4'hF, e);
      apbWrite(12'h000, 32'h1, 4'hF, e);
      waitCnt(64'd5, 30, "reach_cmp1");
      checkOutput("int_at_match", 64'(tim_int), 64'd0);
      @(negedge clk);
      checkOutput("int_match_p1", 64'(tim_int), 64'd0);
      @(negedge clk);
      checkOutput("int_match_p2", 64'(tim_int), 64'd1);
      checkOutput("int_ch_match_p2", 64'(tim_int_ch), 64'h2);
      apbRead(12'h010, d);
      checkOutput("tisr_after_match", 64'(d), 64'h2);
      apbWrite(12'h010, 32'h2, 4'hF, e);
      repeat (2) @(negedge clk);
      checkOutput("int_cleared", 64'(tim_int), 64'd0);
      checkOutput("int_ch_cleared", 64'(tim_int_ch), 64'd0);
      apbWrite(12'h000, 32'h0, 4'hF, e);
      @(negedge clk);
      checkOutput("stop_clears_cnt", cnt_value, 64'd0);

      // Prescaler and TCR error rules
      apbWrite(12'h000, 32'h303, 4'hF, e);
      waitCnt(64'd1, 20, "div_first_tick");
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (cnt_value != 64'd2 && n < 40);
      checkOutput("div_period", 64'(n), 64'd8);
      apbWrite(12'h000, 32'h403, 4'hF, e);
      checkOutput("tcr_err_running", 64'(e), 64'd1);
      apbRead(12'h000, d);
      checkOutput("tcr_kept", 64'(d), 64'h303);
      apbWrite(12'h000, 32'h302, 4'hF, e);
      checkOutput("tcr_stop_ok", 64'(e), 64'd0);
      apbWrite(12'h000, 32'h900, 4'h2, e);
      checkOutput("tcr_err_divval", 64'(e), 64'd1);
      apbWrite(12'h000, 32'h900, 4'h1, e);
      checkOutput("tcr_no_err_lane0", 64'(e), 64'd0);
      apbRead(12'h000, d);
      checkOutput("tcr_after_lane0", 64'(d), 64'h300);

      // Counter loads with byte strobes, then a 32-bit rollover
      apbWrite(12'h004, 32'h1234_5678, 4'hF, e);
      @(negedge clk);
      checkOutput("tdr0_load", cnt_value, 64'h1234_5678);
      apbWrite(12'h004, 32'h0000_00AA, 4'h1, e);
      @(negedge clk);
      checkOutput("tdr0_byte0", cnt_value, 64'h1234_56AA);
      apbWrite(12'h008, 32'hDEAD_BEEF, 4'hC, e);
      @(negedge clk);
      checkOutput("tdr1_upper", cnt_value, 64'hDEAD_0000_1234_56AA);
      apbRead(12'h008, d);
      checkOutput("tdr1_read", 64'(d), 64'hDEAD_0000);
      apbWrite(12'h004, 32'hFFFF_FFFF, 4'hF, e);
      apbWrite(12'h008, 32'h0, 4'hF, e);
      apbWrite(12'h000, 32'h1, 4'hF, e);
      waitCnt(64'h1_0000_0000, 20, "rollover_32");
      apbRead(12'h008, d);
      apbWrite(12'h000, 32'h0, 4'hF, e);

      // Periodic auto-clear at TCMP0
      apbWrite(12'h020, 32'd3, 4'hF, e);
      apbWrite(12'h024, 32'd0, 4'hF, e);
      apbWrite(12'h010, 32'hF, 4'h1, e);
      apbWrite(12'h000, 32'h10001, 4'hF, e);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         checkOutput("autoclr_seq", cnt_value, 64'(i % 4));
      end
      apbRead(12'h010, d);
      checkOutput("autoclr_status", 64'(d[0]), 64'd1);
      apbWrite(12'h010, 32'h1, 4'h1, e);
      repeat (6) @(negedge clk);
      apbRead(12'h010, d);
      checkOutput("autoclr_status_again", 64'(d[0]), 64'd1);

      // Debug halt handshake
      apbWrite(12'h014, 32'h1, 4'h1, e);
      apbRead(12'h014, d);
      checkOutput("thcsr_req_only", 64'(d), 64'h1);
      @(posedge clk); #1;
      dbg_mode = 1'b1;
      apbRead(12'h014, d);
      checkOutput("thcsr_halted", 64'(d), 64'h3);
      @(negedge clk);
      frozen = m_cnt;
      repeat (5) @(negedge clk);
      checkOutput("halt_freeze", cnt_value, frozen);
      @(posedge clk); #1;
      dbg_mode = 1'b0;
      repeat (6) @(negedge clk);
      apbWrite(12'h014, 32'h0, 4'h1, e);
      apbWrite(12'h000, 32'h0, 4'hF, e);

      // Randomized traffic against the model
      applyStimulus(300);

      // Asynchronous reset in the middle of operation
      apbWrite(12'h000, 32'h1, 4'hF, e);
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_cnt", cnt_value, 64'd0);
      checkOutput("midrst_int", 64'(tim_int), 64'd0);
      checkOutput("midrst_int_ch", 64'(tim_int_ch), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      apbRead(12'h000, d);
      checkOutput("midrst_tcr", 64'(d), 64'h100);
      apbRead(12'h020, d);
      checkOutput("midrst_tcmp0", 64'(d), 64'hFFFF_FFFF);
      repeat (5) @(negedge clk);
      checkOutput("midrst_cnt_idle", cnt_value, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
